// File: rtl/bsr_scan_sequencer.sv
// ============================================================================
// Module  : bsr_scan_sequencer
// Purpose : Autonomous shift-in / update / capture / shift-out sequencer for
//           the BSR chain. Optional compare feature: BSR_SEQ_COMPARE_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module bsr_scan_sequencer #(
  parameter int CHAIN_LEN = 5
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] vector,
`ifdef BSR_SEQ_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 mismatch,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 bsr_tdi,
  input  logic                 bsr_tdo,
  output logic                 bsr_clk,
  output logic                 bsr_shift,
  output logic                 bsr_update,
  output logic                 bsr_mode
);

  localparam int                CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_UPDATE    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SHIFT_OUT = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t                 r_state, w_state;
  logic                   r_phase, w_phase;   // 0 = low half of a scan pulse, 1 = high half
  logic [CNT_W-1:0]       r_cnt,   w_cnt;
  logic [CHAIN_LEN-1:0]   r_vec,   w_vec;
  logic [CHAIN_LEN-1:0]   r_shreg, w_shreg;
  logic [CHAIN_LEN-1:0]   w_response;
  logic                   w_busy, w_done, w_tdi, w_clk, w_shift, w_update, w_mode;
`ifdef BSR_SEQ_COMPARE_EN
  logic [CHAIN_LEN-1:0]   r_exp, w_exp;
  logic                   w_mismatch;
`endif

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_cnt   = r_cnt;
    w_vec   = r_vec;
    w_shreg = r_shreg;
`ifdef BSR_SEQ_COMPARE_EN
    w_exp   = r_exp;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state = ST_SHIFT_IN;
          w_vec   = vector;
`ifdef BSR_SEQ_COMPARE_EN
          w_exp   = expected;
`endif
          w_cnt   = '0;
          w_phase = 1'b0;
        end
      end
      ST_SHIFT_IN: begin
        if (!r_phase) begin
          w_phase = 1'b1;
        end else begin
          w_phase = 1'b0;
          if (r_cnt == LAST) begin
            w_state = ST_UPDATE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        w_state = ST_CAPTURE;
        w_phase = 1'b0;
      end
      ST_CAPTURE: begin
        if (!r_phase) begin
          w_phase = 1'b1;
        end else begin
          w_phase = 1'b0;
          w_state = ST_SHIFT_OUT;
          w_cnt   = '0;
        end
      end
      ST_SHIFT_OUT: begin
        if (!r_phase) begin
          // tdo is stable during the low half; the chain moves on the rising bsr_clk
          w_phase = 1'b1;
          w_shreg = {r_shreg[CHAIN_LEN-2:0], bsr_tdo};
        end else begin
          w_phase = 1'b0;
          if (r_cnt == LAST) begin
            w_state = ST_DONE;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_phase = 1'b0;
        w_cnt   = '0;
      end
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_state = ST_IDLE;
      w_phase = 1'b0;
      w_cnt   = '0;
    end

    // Outputs are registered from the next state so they line up with it
    w_busy   = (w_state != ST_IDLE);
    w_mode   = (w_state != ST_IDLE);
    w_done   = (w_state == ST_DONE);
    w_update = (w_state == ST_UPDATE);
    w_shift  = (w_state == ST_SHIFT_IN) || (w_state == ST_SHIFT_OUT);
    w_clk    = w_phase && (w_state inside {ST_SHIFT_IN, ST_CAPTURE, ST_SHIFT_OUT});

    w_tdi = 1'b0;
    if (w_state == ST_SHIFT_IN) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (w_cnt == CNT_W'(CHAIN_LEN - 1 - i)) w_tdi = w_vec[i];
      end
    end

    w_response = (w_state == ST_DONE) ? r_shreg : response;
`ifdef BSR_SEQ_COMPARE_EN
    w_mismatch = (w_state == ST_DONE) ? (r_shreg != r_exp) : mismatch;
`endif
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_state    <= ST_IDLE;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_vec      <= '0;
      r_shreg    <= '0;
      response   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bsr_tdi    <= 1'b0;
      bsr_clk    <= 1'b0;
      bsr_shift  <= 1'b0;
      bsr_update <= 1'b0;
      bsr_mode   <= 1'b0;
`ifdef BSR_SEQ_COMPARE_EN
      r_exp      <= '0;
      mismatch   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_phase    <= w_phase;
      r_cnt      <= w_cnt;
      r_vec      <= w_vec;
      r_shreg    <= w_shreg;
      response   <= w_response;
      busy       <= w_busy;
      done       <= w_done;
      bsr_tdi    <= w_tdi;
      bsr_clk    <= w_clk;
      bsr_shift  <= w_shift;
      bsr_update <= w_update;
      bsr_mode   <= w_mode;
`ifdef BSR_SEQ_COMPARE_EN
      r_exp      <= w_exp;
      mismatch   <= w_mismatch;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsr_scan_sequencer.sv
// ============================================================================
// Module  : tb_bsr_scan_sequencer
// Purpose : Vector-table bench with a behavioural 5-cell chain + full adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsr_scan_sequencer;

  logic       tck = 1'b0;
  logic       trst, start, abort;
  logic [4:0] vector;
  logic       busy, done;
  logic [4:0] response;
  logic       bsr_tdi, bsr_tdo, bsr_clk, bsr_shift, bsr_update, bsr_mode;
`ifdef BSR_SEQ_COMPARE_EN
  logic [4:0] expected;
  logic       mismatch;
`endif

  int errors = 0;
  int checks = 0;

  always #5 tck = ~tck;

  bsr_scan_sequencer #(.CHAIN_LEN(5)) dut (
    .tck        (tck),
    .trst       (trst),
    .start      (start),
    .abort      (abort),
    .vector     (vector),
`ifdef BSR_SEQ_COMPARE_EN
    .expected   (expected),
    .mismatch   (mismatch),
`endif
    .busy       (busy),
    .done       (done),
    .response   (response),
    .bsr_tdi    (bsr_tdi),
    .bsr_tdo    (bsr_tdo),
    .bsr_clk    (bsr_clk),
    .bsr_shift  (bsr_shift),
    .bsr_update (bsr_update),
    .bsr_mode   (bsr_mode)
  );

  // Chain model: cells 0..2 = pins a,b,c; cell 3 = sum; cell 4 = carry
  logic [4:0] cells = '0;
  logic [4:0] upd   = '0;
  logic [2:0] pins  = '0;   // {c,b,a}
  logic [2:0] core_in;
  logic       sum, carry;

  assign core_in      = bsr_mode ? upd[2:0] : pins;
  assign {carry, sum} = {1'b0, core_in[0]} + {1'b0, core_in[1]} + {1'b0, core_in[2]};
  assign bsr_tdo      = cells[4];

  always @(posedge bsr_clk)    cells <= bsr_shift ? {cells[3:0], bsr_tdi} : {carry, sum, pins};
  always @(posedge bsr_update) upd   <= cells;

  typedef struct {
    logic [2:0] pins;
    logic [4:0] vec;
    logic [4:0] resp;
    logic [4:0] exp;
    logic       mm;
  } rec_t;

  rec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Cycle n below is the n-th cycle after the edge that samples start.
  task automatic run_rec(input rec_t r);
    int         done_cnt = 0;
    int         done_at  = -1;
    logic [4:0] seq      = '0;
    logic       busy_ok  = 1'b1;
    logic       mode_ok  = 1'b1;
    logic       clk_ok   = 1'b1;
    logic       exp_clk;
    @(negedge tck);
    pins   = r.pins;
    vector = r.vec;
`ifdef BSR_SEQ_COMPARE_EN
    expected = r.exp;
`endif
    start  = 1'b1;
    @(negedge tck);
    start  = 1'b0;
    vector = ~r.vec;
`ifdef BSR_SEQ_COMPARE_EN
    expected = ~r.exp;
`endif
    for (int n = 1; n <= 28; n++) begin
      if (n > 1) @(negedge tck);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (busy !== (n <= 24)) busy_ok = 1'b0;
      if (bsr_mode !== (n <= 24)) mode_ok = 1'b0;
      exp_clk = (n <= 10) ? (n % 2 == 0) : ((n >= 12 && n <= 23) ? (n % 2 == 1) : 1'b0);
      if (bsr_clk !== exp_clk) clk_ok = 1'b0;
      if (n <= 10 && n % 2 == 1) seq = {seq[3:0], bsr_tdi};
    end
    chk("done_cycle", done_at, 24);
    chk("done_count", done_cnt, 1);
    chk("busy_window", busy_ok, 1);
    chk("mode_window", mode_ok, 1);
    chk("clk_pattern", clk_ok, 1);
    chk("tdi_sequence", seq, r.vec);
    chk("response", response, r.resp);
`ifdef BSR_SEQ_COMPARE_EN
    chk("mismatch", mismatch, r.mm);
`endif
  endtask

  initial begin
    tbl[0] = '{pins: 3'b000, vec: 5'b00011, resp: 5'b10000, exp: 5'b10000, mm: 1'b0};
    tbl[1] = '{pins: 3'b101, vec: 5'b00111, resp: 5'b11101, exp: 5'b11101, mm: 1'b0};
    tbl[2] = '{pins: 3'b111, vec: 5'b00101, resp: 5'b10111, exp: 5'b10111, mm: 1'b0};
    tbl[3] = '{pins: 3'b010, vec: 5'b00001, resp: 5'b01010, exp: 5'b00000, mm: 1'b1};
    tbl[4] = '{pins: 3'b110, vec: 5'b11000, resp: 5'b00110, exp: 5'b00110, mm: 1'b0};
    tbl[5] = '{pins: 3'b101, vec: 5'b00111, resp: 5'b11101, exp: 5'b01101, mm: 1'b1};

    trst = 1'b1; start = 1'b0; abort = 1'b0; vector = '0;
`ifdef BSR_SEQ_COMPARE_EN
    expected = '0;
`endif
    repeat (2) @(negedge tck);
    chk("reset_outputs", {busy, done, bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode, response}, 0);
    trst = 1'b0;

    for (int i = 0; i < 6; i++) run_rec(tbl[i]);

    // response/mismatch hold while idle
    repeat (10) @(negedge tck);
    chk("response_hold", response, 5'b11101);
`ifdef BSR_SEQ_COMPARE_EN
    chk("mismatch_hold", mismatch, 1'b1);
`endif

    // start pulses mid-run and in DONE are ignored
    begin
      int dcnt = 0;
      int dat  = -1;
      pins = 3'b000; vector = 5'b00011; start = 1'b1;
      @(negedge tck); start = 1'b0;
      for (int n = 1; n <= 50; n++) begin
        if (n > 1) @(negedge tck);
        if (done === 1'b1) begin dcnt++; if (dat < 0) dat = n; end
        if (n == 25) chk("idle_after_done_start", busy, 1'b0);
        start = (n == 3 || n == 24);
      end
      start = 1'b0;
      chk("ignored_start_done_count", dcnt, 1);
      chk("ignored_start_done_cycle", dat, 24);
      chk("ignored_start_response", response, 5'b10000);
    end

    // abort during CAPTURE
    run_rec(tbl[1]);
    begin
      int dcnt = 0;
      @(negedge tck); pins = 3'b000; vector = 5'b00011; start = 1'b1;
      @(negedge tck); start = 1'b0;
      for (int n = 1; n <= 30; n++) begin
        if (n > 1) @(negedge tck);
        if (done === 1'b1) dcnt++;
        if (n == 12) begin
          chk("in_capture", {bsr_mode, bsr_shift, bsr_update, bsr_clk}, 4'b1000);
          abort = 1'b1;
        end
        if (n == 13) begin
          abort = 1'b0;
          chk("abort_outputs", {busy, bsr_mode, bsr_tdi, bsr_clk, bsr_shift, bsr_update}, 0);
          chk("abort_response_kept", response, 5'b11101);
        end
      end
      chk("abort_no_done", dcnt, 0);
    end

    // abort and start together in IDLE
    @(negedge tck); start = 1'b1; abort = 1'b1;
    @(negedge tck); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 1'b0);

    // asynchronous reset mid-SHIFT_OUT
    begin
      int dcnt = 0;
      @(negedge tck); pins = 3'b111; vector = 5'b00101; start = 1'b1;
      @(negedge tck); start = 1'b0;
      for (int n = 2; n <= 16; n++) @(negedge tck);
      chk("pre_reset_shift_out", {busy, bsr_shift, bsr_update}, 3'b110);
      #1 trst = 1'b1;
      #1 chk("async_reset_outputs",
             {busy, done, bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode, response}, 0);
      @(negedge tck); trst = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge tck);
        if (done === 1'b1) dcnt++;
      end
      chk("reset_no_done", dcnt, 0);
    end
    run_rec(tbl[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
